// File: rtl/apb_slave_mux_pkg.sv
// Shared definitions for the APB slave fan-out / response-return stage.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 16
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_slave_mux_pkg;

  localparam int PADDR_W = `PADDR_WIDTH;
  localparam int DATA_W  = `APB_DATA_WIDTH;

  // timeout event counter saturates here
  localparam logic [7:0] TOUT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_slave_mux_if.sv
// Bridge-side and slave-side APB signals seen by the slave mux.
interface apb_slave_mux_if #(
  parameter int NUM_SLV = 4
);
  import apb_slave_mux_pkg::*;

  logic                      psel_en;
  logic                      penable;
  logic [PADDR_W-1:0]        paddr;
  logic                      pwrite;
  logic [NUM_SLV-1:0]        psel;
  logic [NUM_SLV*DATA_W-1:0] prdata_s;
  logic [NUM_SLV-1:0]        pready_s;
  logic [NUM_SLV-1:0]        pslverr_s;
  logic                      pready_x;
  logic                      pslverr_x;
  logic [DATA_W-1:0]         hrdata;

  // the mux itself
  modport slave (
    input  psel_en, penable, paddr, pwrite, prdata_s, pready_s, pslverr_s,
    output psel, pready_x, pslverr_x, hrdata
  );

  // bridge plus attached slaves
  modport master (
    output psel_en, penable, paddr, pwrite, prdata_s, pready_s, pslverr_s,
    input  psel, pready_x, pslverr_x, hrdata
  );

endinterface

// File: rtl/apb_wdt_cnt.sv
// Wait-state watchdog: counts unready access cycles of one transfer and
// flags the last permitted one.
module apb_wdt_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt;

  assign tc = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // clear has priority; holding at terminal count avoids wrapping if the
  // transfer is somehow not closed by the hit
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      wait_cnt <= '0;
    else if (clr)
      wait_cnt <= '0;
    else if (inc && !tc)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/apb_slave_mux.sv
// APB fan-out downstream of the AHB-to-APB bridge: decodes paddr into
// one-hot selects, returns the selected slave's response, registers read
// data and bounds every transfer with a wait-state watchdog.
module apb_slave_mux
  import apb_slave_mux_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  apb_slave_mux_if.slave        bus,
  input  logic                  err_clr,
  output logic [7:0]            tout_cnt
);

  apb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_q;
  logic              unmapped;
  logic              acc, done, abort, tout_hit;
  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              wdt_clr, wdt_inc, wdt_tc;

  // live decode while idle so psel is valid in the bridge's setup cycle
  assign idx      = (state == ST_IDLE) ? bus.paddr[PADDR_W-1 -: IDX_W] : idx_q;
  assign unmapped = (int'(idx) >= NUM_SLV);

  // pick the addressed slave's response; unmapped indices read as zero
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(idx) == i) begin
        sel_ready = bus.pready_s[i];
        sel_err   = bus.pslverr_s[i];
        sel_rdata = bus.prdata_s[i*DATA_W +: DATA_W];
      end
    end
  end

  // state register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.psel_en)
          state_nxt = done ? ST_RELEASE : (bus.penable ? ST_ACCESS : ST_SETUP);
      end
      ST_SETUP, ST_ACCESS: begin
        if (!bus.psel_en)
          state_nxt = ST_IDLE;
        else if (done)
          state_nxt = ST_RELEASE;
        else
          state_nxt = ST_ACCESS;
      end
      ST_RELEASE: begin
        if (!bus.psel_en)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // zero-latency selects and response; reset forces them low at once
  always_comb begin
    acc           = bus.psel_en & bus.penable & (state != ST_RELEASE) & !hreset;
    tout_hit      = acc & !unmapped & !sel_ready & wdt_tc;
    bus.pready_x  = acc & (unmapped | sel_ready | tout_hit);
    bus.pslverr_x = acc & (unmapped | tout_hit | (sel_ready & sel_err));
    done          = acc & bus.pready_x;
    abort         = !bus.psel_en & ((state == ST_SETUP) | (state == ST_ACCESS));
    wdt_clr       = (state == ST_IDLE) | abort | done;
    wdt_inc       = acc & !sel_ready;
    bus.psel      = '0;
    for (int i = 0; i < NUM_SLV; i++)
      bus.psel[i] = bus.psel_en & (state != ST_RELEASE) & !unmapped & !hreset
                    & (int'(idx) == i);
  end

  // hold the decoded index for the rest of the transfer
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      idx_q <= '0;
    else if (state == ST_IDLE && bus.psel_en)
      idx_q <= bus.paddr[PADDR_W-1 -: IDX_W];
  end

  // read data only captured on a clean read completion
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      bus.hrdata <= '0;
    else if (done && !bus.pwrite && !bus.pslverr_x)
      bus.hrdata <= sel_rdata;
  end

  // timeout event counter; clear wins over a simultaneous hit
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      tout_cnt <= '0;
    else if (err_clr)
      tout_cnt <= '0;
    else if (tout_hit && done && tout_cnt != TOUT_MAX)
      tout_cnt <= tout_cnt + 8'd1;
  end

  apb_wdt_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .hclk   (hclk),
    .hreset (hreset),
    .clr    (wdt_clr),
    .inc    (wdt_inc),
    .tc     (wdt_tc)
  );

endmodule

// File: tb/tb_apb_slave_mux.sv
// Scoreboard bench for apb_slave_mux.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 16
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module tb_apb_slave_mux;
  import apb_slave_mux_pkg::*;

  localparam int NS = 4;
  localparam int TO = 16;

  logic       hclk = 1'b0;
  logic       hreset = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] tout_cnt;

  apb_slave_mux_if #(.NUM_SLV(NS)) bus();

  apb_slave_mux #(
    .NUM_SLV (NS),
    .IDX_W   (3),
    .TIMEOUT (TO)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .bus      (bus),
    .err_clr  (err_clr),
    .tout_cnt (tout_cnt)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [NS-1:0] psel;
    int            cycles;
    logic          err;
    logic [31:0]   hrdata;
    logic [7:0]    tout;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hrdata = '0;
  logic [7:0]  m_tout = '0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // nwait < 0 means the slave never becomes ready
  task automatic do_xfer(input logic [15:0] addr, input bit wr, input int nwait,
                         input bit serr, input logic [31:0] data);
    int   idx;
    bit   unm, hit, seen;
    exp_t e;
    idx    = int'(addr[15:13]);
    unm    = (idx >= NS);
    hit    = 1'b0;
    e.psel = '0;
    if (!unm) e.psel[idx] = 1'b1;
    if (unm) begin
      e.cycles = 1; e.err = 1'b1;
    end else if (nwait < 0 || nwait >= TO) begin
      e.cycles = TO; e.err = 1'b1; hit = 1'b1;
    end else begin
      e.cycles = nwait + 1; e.err = serr;
    end
    if (!wr && !e.err) m_hrdata = data;
    if (hit && m_tout != 8'hFF) m_tout = m_tout + 8'd1;
    e.hrdata = m_hrdata;
    e.tout   = m_tout;
    sb.push_back(e);

    @(posedge hclk); #1;
    bus.psel_en   = 1'b1;
    bus.penable   = 1'b0;
    bus.paddr     = addr;
    bus.pwrite    = wr;
    bus.pready_s  = '0;
    bus.pslverr_s = '0;
    bus.prdata_s  = {NS{~data}};
    if (!unm) bus.prdata_s[idx*32 +: 32] = data;
    #1;
    chk("psel_setup", 32'(bus.psel), 32'(e.psel));
    chk("rdy_setup", 32'(bus.pready_x), 32'd0);

    seen = 1'b0;
    for (int cyc = 1; cyc <= TO + 4 && !seen; cyc++) begin
      @(posedge hclk); #1;
      bus.penable = 1'b1;
      if (!unm && nwait >= 0 && cyc > nwait) begin
        bus.pready_s[idx]  = 1'b1;
        bus.pslverr_s[idx] = serr;
      end
      #1;
      if (bus.pready_x) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("cycles", 32'(cyc), 32'(e.cycles));
          chk("pslverr", 32'(bus.pslverr_x), 32'(e.err));
          chk("psel_acc", 32'(bus.psel), 32'(e.psel));
        end
      end
    end
    if (!seen) begin
      chk("no_ready", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end

    // release cycle: bridge still selecting, mux must stay quiet
    @(posedge hclk); #1;
    bus.penable   = 1'b0;
    bus.pready_s  = '0;
    bus.pslverr_s = '0;
    #1;
    chk("psel_rel", 32'(bus.psel), 32'd0);
    chk("rdy_rel", 32'(bus.pready_x), 32'd0);
    chk("hrdata", bus.hrdata, e.hrdata);
    chk("tout_cnt", 32'(tout_cnt), 32'(e.tout));
    @(posedge hclk); #1;
    bus.psel_en = 1'b0;
  endtask

  initial begin
    bus.psel_en   = 1'b0;
    bus.penable   = 1'b0;
    bus.paddr     = '0;
    bus.pwrite    = 1'b0;
    bus.prdata_s  = '0;
    bus.pready_s  = '0;
    bus.pslverr_s = '0;
    #12;
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_rdy", 32'(bus.pready_x), 32'd0);
    chk("rst_err", 32'(bus.pslverr_x), 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_tout", 32'(tout_cnt), 32'd0);
    @(negedge hclk) hreset = 1'b0;

    do_xfer(16'h4010, 1'b0, 0, 1'b0, 32'hA5A5_1234);   // read slave 2
    do_xfer(16'h0000, 1'b1, 3, 1'b0, 32'h0BAD_0001);   // write slave 0, 3 waits
    do_xfer(16'h2000, 1'b0, -1, 1'b0, 32'h0BAD_0002);  // slave 1 stalls
    do_xfer(16'hA000, 1'b0, 0, 1'b0, 32'h0BAD_0003);   // unmapped
    do_xfer(16'h6000, 1'b0, 0, 1'b1, 32'h0BAD_0004);   // slave error
    do_xfer(16'h0004, 1'b0, 1, 1'b0, 32'h1111_2222);   // back-to-back read
    do_xfer(16'h4020, 1'b0, TO - 1, 1'b0, 32'h3333_4444); // slave beats watchdog

    for (int n = 0; n < 10; n++)
      do_xfer({3'($urandom_range(0, 7)), 13'($urandom)}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom);

    for (int n = 0; n < 256; n++)
      do_xfer(16'h2000 | 16'(n), 1'(n & 1), -1, 1'b0, 32'(n));
    chk("tout_sat", 32'(tout_cnt), 32'hFF);

    @(posedge hclk); #1 err_clr = 1'b1;
    @(posedge hclk); #1 err_clr = 1'b0;
    #1 chk("tout_clr", 32'(tout_cnt), 32'd0);
    m_tout = '0;

    do_xfer(16'h0008, 1'b0, 0, 1'b0, 32'hCAFE_0042);

    // async reset in the middle of an access cycle
    @(posedge hclk); #1;
    bus.psel_en = 1'b1; bus.penable = 1'b0; bus.paddr = 16'h2000; bus.pwrite = 1'b0;
    @(posedge hclk); #1 bus.penable = 1'b1;
    @(posedge hclk); #1 bus.pready_s[1] = 1'b1;
    #1;
    chk("rdy_pre_rst", 32'(bus.pready_x), 32'd1);
    chk("psel_pre_rst", 32'(bus.psel), 32'd2);
    hreset = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(bus.psel), 32'd0);
    chk("rst_mid_rdy", 32'(bus.pready_x), 32'd0);
    chk("rst_mid_err", 32'(bus.pslverr_x), 32'd0);
    chk("rst_mid_hrdata", bus.hrdata, 32'd0);
    chk("rst_mid_tout", 32'(tout_cnt), 32'd0);
    bus.psel_en = 1'b0; bus.penable = 1'b0; bus.pready_s = '0;
    sb.delete();
    m_hrdata = '0;
    m_tout   = '0;
    @(negedge hclk) hreset = 1'b0;

    do_xfer(16'h6004, 1'b0, 2, 1'b0, 32'h5A5A_0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
